// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control unit: FSM sequencing fetch through writeback,
// with branch resolution, memory handshake stalls, illegal-op trap and instret.
module riscv_multicycle_ctrl #(
    parameter bit BRANCH_EXT    = 1'b1,
    parameter bit HAS_JALR      = 1'b1,
    parameter bit HAS_LUI       = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR, S_JALRWB, S_LUI, S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic             w_rdy;
    logic             w_br_ok;
    logic             w_taken;
    logic             w_branch;
    logic             w_pcupd;
    logic             w_retire;

    assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        w_br_ok = 1'b0;
        w_taken = 1'b0;
        unique case (funct3)
            3'b000: begin w_br_ok = 1'b1;       w_taken = zero;  end
            3'b001: begin w_br_ok = BRANCH_EXT; w_taken = !zero; end
            3'b100: begin w_br_ok = BRANCH_EXT; w_taken = lt;    end
            3'b101: begin w_br_ok = BRANCH_EXT; w_taken = !lt;   end
            3'b110: begin w_br_ok = BRANCH_EXT; w_taken = ltu;   end
            3'b111: begin w_br_ok = BRANCH_EXT; w_taken = !ltu;  end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:    if (w_rdy) w_next = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BR:        w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = HAS_JALR ? S_JALR : S_TRAP;
                    OP_LUI:       w_next = HAS_LUI ? S_LUI : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
            S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: w_next = S_ALUWB;
            S_JALR:     w_next = S_JALRWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JALRWB: w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || (r_state == S_JALRWB) ||
                      ((r_state == S_MEMWRITE) && w_rdy);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
            if (w_retire)
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        w_branch  = 1'b0;
        w_pcupd   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_rdy;
                w_pcupd   = w_rdy;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcupd = 1'b1; end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcupd   = 1'b1;
            end
            S_JALRWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        unique case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    assign PCWrite = w_pcupd | (w_branch & w_taken);
    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Parametrised multicycle control unit for the RV32I core. It is the successor to the single-cycle main decoder: one FSM sequences fetch, decode, execute, memory and writeback over several cycles. It generates datapath mux selects and write enables, resolves full-condition branches, stalls on a memory ready handshake, traps illegal opcodes, and counts retired instructions. It sits between the instruction register (op, funct3), the ALU flags, and the shared instruction/data memory port.

Parameters:
BRANCH_EXT, 1, 1 = support bne/blt/bge/bltu/bgeu; 0 = beq only.
HAS_JALR, 1, 1 = decode jalr (op 1100111); 0 = treat as illegal.
HAS_LUI, 1, 1 = decode lui (op 0110111); 0 = treat as illegal.
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
op  in  7  instruction opcode from the instruction register.
funct3  in  3  instruction funct3.
zero  in  1  ALU result == 0.
lt  in  1  signed rs1 < rs2.
ltu  in  1  unsigned rs1 < rs2.
mem_ready  in  1  memory completes the current access this cycle.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register and OldPC enable.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4.
ALUOp  out  2  00 add, 01 sub/compare, 10 by funct.
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
RegWrite  out  1  register file write enable.
illegal  out  1  sticky trap flag.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, instret=0, illegal=0. All outputs are at their FETCH values. Reset mid-instruction abandons it with no writes.
- Outputs are Moore, decoded from state. Unlisted signals are 0, and ALUSrcA/B, ResultSrc and ALUOp default to 00.
- ImmSrc is combinational from op, independent of state:
  - lw, I-ALU, jalr: 000
  - sw: 001
  - branch: 010
  - jal: 011
  - lui: 100
  - other: 000
- PCWrite = PCUpdate | (Branch & taken).
- Branch taken decode (funct3):
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
- FSM states and per-state signals:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCUpdate are asserted only when mem_ready. Stay while !mem_ready; go to DECODE on mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch target into ALUOut). Next state by op:
    - lw/sw (0000011/0100011): MEMADR
    - 0110011: EXECR
    - 0010011: EXECI
    - 1100011: BRANCH if funct3 is supported, else TRAP. With BRANCH_EXT=0 only 000 is supported; 010/011 are always TRAP.
    - 1101111: JAL
    - 1100111: JALR if HAS_JALR
    - 0110111: LUI if HAS_LUI
    - anything else: TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01. Go to MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Retire, then FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held high while waiting. On mem_ready retire, then FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Retire, then FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Retire, then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Then ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCUpdate=1. Then JALRWB.
  - JALRWB: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1. Retire, then FETCH.
  - LUI: ALUSrcA=11, ALUSrcB=01. Then ALUWB.
  - TRAP: illegal=1, all enables 0. Absorbing state; only reset leaves it.
- Retire: instret increments by 1 on the clock edge leaving a final state. It wraps modulo 2^CNT_W and never counts in TRAP.
- Latency in cycles with mem_ready=1:
  - lw: 5
  - sw: 4
  - R/I-type: 4
  - branch: 3
  - jal: 4
  - jalr: 4
  - lui: 4
- Each memory wait cycle adds 1 cycle in FETCH, MEMREAD or MEMWRITE.
- MEM_HANDSHAKE=0: mem_ready is ignored and no wait states occur.

Test Plan:
- Reset, then add (op 0110011) with mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4; instret goes 0 → 1.
- lw with mem_ready held low for 2 cycles in FETCH and 3 in MEMREAD → total 10 cycles. IRWrite pulses exactly once; RegWrite with ResultSrc=01 once.
- bne (funct3 001) with zero=0 → PCWrite=1 in the BRANCH cycle. Repeat with zero=1 → PCWrite=0. With BRANCH_EXT=0, bne → TRAP and illegal=1.
- jalr → JALR cycle has PCWrite=1, ResultSrc=10. JALRWB has RegWrite=1, ALUSrcA=01, ALUSrcB=10. instret increments once.
- op 1111111 → TRAP: illegal stays 1, all enables 0, instret frozen for 20 cycles. Assert reset_n=0 mid-TRAP → immediate FETCH, illegal=0, instret=0.
- CNT_W=4: retire 17 instructions → instret=1 (wrap). Reset asserted during MEMWRITE → MemWrite drops asynchronously with no retire.
